ccr_arbiter: RTL
================

Name: ccr_arbiter

Overview:
- Shares the 4-bit condition-code register (CCR) write path between two requesters: A = ALU status update, B = explicit CCR load from the control unit.
- Drives the select of the 4-bit 2:1 CCR source mux (sel=0 picks A, sel=1 picks B) and captures the mux result into the CCR.
- Sits between the ALU/control unit and the CCR consumers (branch logic); replaces the hard-wired CCR select.

Parameters:
- HOLD_CYCLES, 0, lock-out cycles inserted after every grant before the next grant; 0 = back-to-back grants allowed; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_a  input  1  requester A wants a CCR write
- data_a  input  4  requester A status value; must be valid while gnt_a=1
- req_b  input  1  requester B wants a CCR write
- data_b  input  4  requester B status value; must be valid while gnt_b=1
- gnt_a  output  1  one-cycle grant to A; CCR written at the end of this cycle
- gnt_b  output  1  one-cycle grant to B; CCR written at the end of this cycle
- sel  output  1  mux select; 1 only in GNT_B, otherwise 0
- ccr  output  4  registered condition codes
- busy  output  1  high in GNT_A, GNT_B and LOCK

Behaviour:
- Reset values: state=IDLE, gnt_a=0, gnt_b=0, sel=0, ccr=4'h0, busy=0, last-served pointer lp=B (so A wins the first tie), lock counter=0.
- Reset is asynchronous. Asserting it mid-grant aborts the write (ccr=0) and drops the grant. The requester keeps req asserted and is re-arbitrated after reset release.
- States:
  - IDLE: waiting for requests.
  - GNT_A / GNT_B: exactly one cycle.
  - LOCK: HOLD_CYCLES cycles; only entered when HOLD_CYCLES>0.
- All outputs are registered decodes of the state. gnt_a=(state==GNT_A); gnt_b=(state==GNT_B); sel=(state==GNT_B).
- Arbitration function, evaluated in IDLE, in GNT_x when HOLD_CYCLES=0, and on the last LOCK cycle:
  - Use masked requests: in GNT_A, req_a is treated as 0; in GNT_B, req_b is treated as 0.
  - Only one request → go to that requester's GNT state.
  - Both requests → grant the requester that is not lp (round-robin).
  - None → IDLE.
- In GNT_x: ccr <= mux output (data_x) at the closing edge; lp <= x.
- After GNT_x:
  - HOLD_CYCLES>0 → LOCK, lock counter loaded with HOLD_CYCLES-1.
  - HOLD_CYCLES=0 → apply the arbitration function directly.
- LOCK: the counter decrements each cycle; the arbitration function is applied in the cycle where the counter==0. No grants are issued while in LOCK.
- Handshake:
  - Requester holds req (and data) until it sees gnt=1.
  - It deasserts req in the cycle after gnt unless it has a new write.
  - Because of masking, one requester is never granted in two consecutive cycles; the minimum grant spacing per requester is 2 cycles.
- Request-to-grant latency: 1 cycle from IDLE (req sampled at edge n, gnt high during cycle n+1).
  - Worst case with contention and HOLD_CYCLES=0: 2 cycles.
  - Worst case with contention and HOLD_CYCLES>0: 2+HOLD_CYCLES cycles.
- ccr changes only at the end of a GNT cycle and holds otherwise.
- Simultaneous req_a/req_b in IDLE directly after reset → A is granted first, then B.

Optional Feature:
- Macro: CCR_ARB_STATS_EN.
- Defined:
  - Adds input clr_stats (1) and outputs cnt_a (8) and cnt_b (8).
  - Each counter increments once per grant to its requester and saturates at 8'hFF.
  - clr_stats=1 synchronously zeroes both counters; clear wins over a same-cycle increment.
  - Counters reset to 0 on rst.
- Undefined: these ports and the counter logic do not exist. All other behaviour is identical.

Test Plan:
- Reset, then req_a=1, data_a=4'hA → gnt_a high 1 cycle after the sampling edge, sel=0, ccr=4'hA the next cycle, busy returns to 0.
- Both requests held, data_a=4'h3, data_b=4'hC, HOLD_CYCLES=0 → grants alternate gnt_a, gnt_b, gnt_a…; sel=1 only on gnt_b cycles; ccr alternates 3/C.
- Single requester holding req continuously → gnt every other cycle, never 2 consecutive cycles.
- HOLD_CYCLES=3, both requesting → gnt_a, 3 LOCK cycles (busy=1, no gnt), then gnt_b.
- rst asserted during GNT_B with data_b=4'hF → ccr=0 immediately, gnt_b=0; after release with req_b still held → gnt_b re-issued, ccr=4'hF.
- With CCR_ARB_STATS_EN: 300 grants to A → cnt_a=8'hFF; clr_stats in a grant cycle → cnt_a=0 the next cycle.

Source files
------------

// File: rtl/ccr_arbiter.sv
// ccr_arbiter: round-robin owner of the 4-bit CCR write path (ALU vs control).
// Optional grant statistics are enabled with `define CCR_ARB_STATS_EN.
module ccr_arbiter #(
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [3:0] data_a,
  input  logic       req_b,
  input  logic [3:0] data_b,
`ifdef CCR_ARB_STATS_EN
  input  logic       clr_stats,
  output logic [7:0] cnt_a,
  output logic [7:0] cnt_b,
`endif
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       sel,
  output logic [3:0] ccr,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GNT_A = 2'd1;
  localparam logic [1:0] S_GNT_B = 2'd2;
  localparam logic [1:0] S_LOCK  = 2'd3;

  localparam bit HOLD_EN = (HOLD_CYCLES != 0);
  localparam logic [3:0] LOCK_INIT =
    (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  logic [1:0] state_q, state_d;
  logic [3:0] lock_q, lock_d;
  logic [3:0] ccr_q, ccr_d;
  logic       lp_q, lp_d;

  logic       mreq_a, mreq_b;
  logic [1:0] arb_nxt;
  logic [3:0] mux_out;

  // Round-robin pick among masked requests; lp_q=1 means B was served last.
  always_comb begin
    mreq_a  = req_a & (state_q != S_GNT_A);
    mreq_b  = req_b & (state_q != S_GNT_B);
    arb_nxt = S_IDLE;
    if (mreq_a && mreq_b)
      arb_nxt = lp_q ? S_GNT_A : S_GNT_B;
    else if (mreq_a)
      arb_nxt = S_GNT_A;
    else if (mreq_b)
      arb_nxt = S_GNT_B;
  end

  assign mux_out = sel ? data_b : data_a;

  // Next-state, lock countdown, CCR capture and last-served update.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ccr_d   = ccr_q;
    lp_d    = lp_q;
    case (state_q)
      S_IDLE: state_d = arb_nxt;
      S_GNT_A, S_GNT_B: begin
        ccr_d = mux_out;
        lp_d  = (state_q == S_GNT_B);
        if (HOLD_EN) begin
          state_d = S_LOCK;
          lock_d  = LOCK_INIT;
        end else begin
          state_d = arb_nxt;
        end
      end
      S_LOCK: begin
        if (lock_q == 4'd0)
          state_d = arb_nxt;
        else
          lock_d = lock_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core state registers; reset aborts any in-flight CCR write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lock_q  <= 4'd0;
      ccr_q   <= 4'h0;
      lp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ccr_q   <= ccr_d;
      lp_q    <= lp_d;
    end
  end

  assign gnt_a = (state_q == S_GNT_A);
  assign gnt_b = (state_q == S_GNT_B);
  assign sel   = (state_q == S_GNT_B);
  assign busy  = (state_q != S_IDLE);
  assign ccr   = ccr_q;

`ifdef CCR_ARB_STATS_EN
  logic [7:0] cnt_a_q, cnt_a_d;
  logic [7:0] cnt_b_q, cnt_b_d;

  // Saturating grant counters; clear beats a same-cycle increment.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (clr_stats) begin
      cnt_a_d = 8'h00;
      cnt_b_d = 8'h00;
    end else begin
      if (gnt_a && cnt_a_q != 8'hFF) cnt_a_d = cnt_a_q + 8'd1;
      if (gnt_b && cnt_b_q != 8'hFF) cnt_b_d = cnt_b_q + 8'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= 8'h00;
      cnt_b_q <= 8'h00;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule
